cache_req_decoder: RTL and testbench

- Parametrised successor to the cache address decoder.
- Splits a CPU address into tag, line and word fields, and registers those fields.
- Holds the fields stable for the whole lookup, miss and refill sequence. Back-pressures the CPU with in_ready until the access completes.
- After a refill, replays the lookup once. Also flags misaligned addresses and counts misses.
- Sits between the CPU load/store port and the cache tag/data arrays and refill engine.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_req_decoder_if.sv | 39 +++
 rtl/cache_req_decoder_sat_counter.sv | 19 +
 rtl/cache_req_decoder.sv | 147 ++++++++++++++
 tb/tb_cache_req_decoder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types, default geometry and field-width helper for the cache request decoder.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MISS_WAIT = 2'd2,
    REPLAY    = 2'd3
  } cache_dec_state_e;

  localparam int unsigned CACHE_ADDR_W        = 32;
  localparam int unsigned CACHE_BYTE_OFF_BITS = 1;
  localparam int unsigned CACHE_WORD_BITS     = 2;
  localparam int unsigned CACHE_LINE_BITS     = 2;

  // Whatever the address holds above line, word and byte offset is tag.
  function automatic int unsigned cache_tag_width(
    input int unsigned addr_w,
    input int unsigned byte_off_bits,
    input int unsigned word_bits,
    input int unsigned line_bits
  );
    return addr_w - byte_off_bits - word_bits - line_bits;
  endfunction

endpackage

// File: rtl/cache_req_decoder_if.sv
// CPU-port, tag-array and refill-engine signals of the cache request decoder.
interface cache_req_decoder_if
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W        = CACHE_ADDR_W,
  parameter int unsigned BYTE_OFF_BITS = CACHE_BYTE_OFF_BITS,
  parameter int unsigned WORD_BITS     = CACHE_WORD_BITS,
  parameter int unsigned LINE_BITS     = CACHE_LINE_BITS,
  parameter int unsigned MISS_CNT_W    = 16
) ();

  localparam int unsigned TAG_W = cache_tag_width(ADDR_W, BYTE_OFF_BITS, WORD_BITS, LINE_BITS);

  logic                  in_req;
  logic [ADDR_W-1:0]     in_addr;
  logic                  in_ready;
  logic [TAG_W-1:0]      tag;
  logic [LINE_BITS-1:0]  line_id;
  logic [WORD_BITS-1:0]  word_id;
  logic                  cpu_req;
  logic                  lookup_hit;
  logic                  lookup_miss;
  logic                  miss_req;
  logic                  miss_done;
  logic                  align_err;
  logic [MISS_CNT_W-1:0] miss_cnt;

  // Environment side: CPU, tag array and refill engine.
  modport master (
    output in_req, in_addr, lookup_hit, lookup_miss, miss_done,
    input  in_ready, tag, line_id, word_id, cpu_req, miss_req, align_err, miss_cnt
  );

  modport slave (
    input  in_req, in_addr, lookup_hit, lookup_miss, miss_done,
    output in_ready, tag, line_id, word_id, cpu_req, miss_req, align_err, miss_cnt
  );

endinterface

// File: rtl/cache_req_decoder_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_req_decoder.sv
// Splits a CPU address into tag/line/word, holds the fields through lookup, miss
// and refill, replays the lookup once after a refill, and counts misses.
module cache_req_decoder
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W        = CACHE_ADDR_W,
  parameter int unsigned BYTE_OFF_BITS = CACHE_BYTE_OFF_BITS,
  parameter int unsigned WORD_BITS     = CACHE_WORD_BITS,
  parameter int unsigned LINE_BITS     = CACHE_LINE_BITS,
  parameter int unsigned MISS_CNT_W    = 16
) (
  input logic                clk,
  input logic                reset,
  cache_req_decoder_if.slave bus
);

  localparam int unsigned TAG_W = cache_tag_width(ADDR_W, BYTE_OFF_BITS, WORD_BITS, LINE_BITS);

  cache_dec_state_e state_q, state_d;

  logic                 in_ready;
  logic                 accept;
  logic                 aligned;
  logic                 resp_ok;
  logic                 capture;
  logic                 miss_inc;
  logic                 cpu_req_q, cpu_req_d;
  logic                 miss_req_q, miss_req_d;
  logic                 align_err_q, align_err_d;
  logic [TAG_W-1:0]     tag_q;
  logic [LINE_BITS-1:0] line_q;
  logic [WORD_BITS-1:0] word_q;

  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = bus.in_req && in_ready;

  // A zero-width byte offset means every address is aligned.
  if (BYTE_OFF_BITS > 0) begin : g_align_chk
    assign aligned = (bus.in_addr[BYTE_OFF_BITS-1:0] == '0);
  end else begin : g_no_align_chk
    assign aligned = 1'b1;
  end

  // Tag-array responses are only meaningful from the cycle after the cpu_req strobe.
  assign resp_ok = (state_q == LOOKUP) && !cpu_req_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; hit and miss together is treated as a miss
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && aligned) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (resp_ok) begin
          if (bus.lookup_miss)     state_d = MISS_WAIT;
          else if (bus.lookup_hit) state_d = IDLE;
        end
      end
      MISS_WAIT: begin
        if (bus.miss_done) state_d = REPLAY;
      end
      REPLAY: begin
        state_d = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cpu_req_d   = 1'b0;
    miss_req_d  = 1'b0;
    align_err_d = 1'b0;
    capture     = 1'b0;
    miss_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        capture     = accept && aligned;
        cpu_req_d   = accept && aligned;
        align_err_d = accept && !aligned;
      end
      LOOKUP: begin
        miss_inc   = resp_ok && bus.lookup_miss;
        miss_req_d = resp_ok && bus.lookup_miss;
      end
      MISS_WAIT: begin
        miss_req_d = !bus.miss_done;
        cpu_req_d  = bus.miss_done;
      end
      REPLAY: begin
        cpu_req_d = 1'b0;
      end
      default: begin
        cpu_req_d = 1'b0;
      end
    endcase
  end

  // Output and field registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_req_q   <= 1'b0;
      miss_req_q  <= 1'b0;
      align_err_q <= 1'b0;
      tag_q       <= '0;
      line_q      <= '0;
      word_q      <= '0;
    end else begin
      cpu_req_q   <= cpu_req_d;
      miss_req_q  <= miss_req_d;
      align_err_q <= align_err_d;
      if (capture) begin
        tag_q  <= bus.in_addr[ADDR_W-1 -: TAG_W];
        line_q <= bus.in_addr[BYTE_OFF_BITS+WORD_BITS +: LINE_BITS];
        word_q <= bus.in_addr[BYTE_OFF_BITS +: WORD_BITS];
      end
    end
  end

  sat_counter #(
    .W (MISS_CNT_W)
  ) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (bus.miss_cnt)
  );

  assign bus.in_ready  = in_ready;
  assign bus.cpu_req   = cpu_req_q;
  assign bus.miss_req  = miss_req_q;
  assign bus.align_err = align_err_q;
  assign bus.tag       = tag_q;
  assign bus.line_id   = line_q;
  assign bus.word_id   = word_q;

endmodule

// File: tb/tb_cache_req_decoder.sv
// Directed bench for cache_req_decoder: a default instance plus a 2-bit miss-counter
// instance sharing the same stimulus.
module tb_cache_req_decoder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   step_no;

  cache_req_decoder_if #(.MISS_CNT_W(16)) bus ();
  cache_req_decoder_if #(.MISS_CNT_W(2))  bus2 ();

  cache_req_decoder #(.MISS_CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cache_req_decoder #(.MISS_CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.in_req      = bus.in_req;
  assign bus2.in_addr     = bus.in_addr;
  assign bus2.lookup_hit  = bus.lookup_hit;
  assign bus2.lookup_miss = bus.lookup_miss;
  assign bus2.miss_done   = bus.miss_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        hit;
    logic        miss;
    logic        done;
    logic        rdy;
    logic        creq;
    logic        mreq;
    logic        aerr;
    logic [31:0] tag;
    logic [1:0]  line;
    logic [1:0]  word;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step_no, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample just after the edge.
  task automatic step(input logic rst, input logic req, input logic [31:0] addr,
                      input logic hit, input logic miss, input logic done);
    reset           = rst;
    bus.in_req      = req;
    bus.in_addr     = addr;
    bus.lookup_hit  = hit;
    bus.lookup_miss = miss;
    bus.miss_done   = done;
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic expect_all(input logic rdy, input logic creq, input logic mreq, input logic aerr,
                            input logic [31:0] tag, input logic [1:0] line, input logic [1:0] word,
                            input logic [15:0] cnt, input logic [1:0] cnt2);
    check("in_ready",  32'(bus.in_ready),  32'(rdy));
    check("cpu_req",   32'(bus.cpu_req),   32'(creq));
    check("miss_req",  32'(bus.miss_req),  32'(mreq));
    check("align_err", 32'(bus.align_err), 32'(aerr));
    check("tag",       32'(bus.tag),       tag);
    check("line_id",   32'(bus.line_id),   32'(line));
    check("word_id",   32'(bus.word_id),   32'(word));
    check("miss_cnt",  32'(bus.miss_cnt),  32'(cnt));
    check("miss_cnt_sat", 32'(bus2.miss_cnt), 32'(cnt2));
  endtask

  initial begin
    int k;
    checks  = 0;
    errors  = 0;
    step_no = 0;

    //          rst   req   addr          hit   miss  done  rdy   creq  mreq  aerr  tag       line  word  cnt    cnt2
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 2'd0, 16'd0, 2'd0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 2'd0, 16'd0, 2'd0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1236, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd0, 2'd0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd0, 2'd0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd0, 2'd0};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_1237, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h91, 2'd2, 2'd3, 16'd0, 2'd0};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd0, 2'd0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_1236, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd0, 2'd0};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd0, 2'd0};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h91, 2'd2, 2'd3, 16'd1, 2'd1};

    reset = 1'b1;
    bus.in_req = 1'b0; bus.in_addr = '0;
    bus.lookup_hit = 1'b0; bus.lookup_miss = 1'b0; bus.miss_done = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].addr, vecs[i].hit, vecs[i].miss, vecs[i].done);
      expect_all(vecs[i].rdy, vecs[i].creq, vecs[i].mreq, vecs[i].aerr, vecs[i].tag,
                 vecs[i].line, vecs[i].word, vecs[i].cnt, vecs[i].cnt2);
    end

    // Long refill with the CPU pushing a new address and a stray hit: nothing moves.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
      expect_all(1'b0, 1'b0, 1'b1, 1'b0, 32'h91, 2'd2, 2'd3, 16'd1, 2'd1);
    end
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);
    expect_all(1'b0, 1'b1, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd1, 2'd1);
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    expect_all(1'b0, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd1, 2'd1);
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
    expect_all(1'b1, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd1, 2'd1);
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    expect_all(1'b0, 1'b1, 1'b0, 1'b0, 32'h07FF_FFFF, 2'd2, 2'd0, 16'd1, 2'd1);
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    expect_all(1'b0, 1'b0, 1'b0, 1'b0, 32'h07FF_FFFF, 2'd2, 2'd0, 16'd1, 2'd1);

    // Hit and miss together counts as a miss.
    step(1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    expect_all(1'b0, 1'b0, 1'b1, 1'b0, 32'h07FF_FFFF, 2'd2, 2'd0, 16'd2, 2'd2);

    // Reset in the middle of a refill, then release.
    step(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    expect_all(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 2'd0, 16'd0, 2'd0);
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    expect_all(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 2'd0, 16'd0, 2'd0);

    // Miss, refill, replay that misses again, refill, replay hit: two misses per pass.
    k = 0;
    for (int p = 0; p < 3; p++) begin
      step(1'b0, 1'b1, 32'h0000_1236, 1'b0, 1'b0, 1'b0);
      expect_all(1'b0, 1'b1, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'(k), 2'((k > 3) ? 3 : k));
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 2; r++) begin
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        k++;
        expect_all(1'b0, 1'b0, 1'b1, 1'b0, 32'h91, 2'd2, 2'd3, 16'(k), 2'((k > 3) ? 3 : k));
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        expect_all(1'b0, 1'b1, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'(k), 2'((k > 3) ? 3 : k));
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      expect_all(1'b1, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'(k), 2'((k > 3) ? 3 : k));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_all(1'b1, 1'b0, 1'b0, 1'b0, 32'h91, 2'd2, 2'd3, 16'd6, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
